// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the single-ported unified memory between instruction
// fetch and the data-memory stage, with halt quiescing and completion timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halt_req,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_HALTED,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              last_dm_q, last_dm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_dm_q   <= 1'b0;
      cnt_q       <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // A pending halt masks fetch entirely; data is still served so the load/store drains.
  assign if_ok = if_req & ~halt_req;

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!mem_stall) begin
          if (dm_req && !(if_ok && last_dm_q)) begin
            last_dm_d   = 1'b1;
            mem_wr_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            state_d     = S_ISSUE;
          end else if (if_ok) begin
            last_dm_d  = 1'b0;
            mem_wr_d   = 1'b0;
            mem_addr_d = if_addr;
            state_d    = S_ISSUE;
          end else if (halt_req && !dm_req) begin
            state_d = S_HALTED;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion is checked first so a mem_done on the expiry cycle still wins.
        if (mem_done) begin
          if (!last_dm_q)     if_rdata_d = mem_rdata;
          else if (!mem_wr_q) dm_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          state_d = S_ERR;
        end
      end
      S_RESP:   state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = (state_q == S_RESP) && !last_dm_q;
  assign dm_done   = (state_q == S_RESP) && last_dm_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign halted    = (state_q == S_HALTED);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory responder plus a
// transaction-level expectation model driven by directed and random steps.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk, rst;
  logic        if_req, dm_req, dm_wr, halt_req, mem_stall, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, dm_done, halted, mem_en, mem_wr, err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .halt_req(halt_req), .halted(halted),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .err(err)
  );

  typedef struct packed { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  typedef struct packed { int cyc; logic [15:0] data; } dn_t;

  iss_t        issues[$];
  dn_t         if_dones[$], dm_dones[$];
  logic [15:0] mem_arr[logic [15:0]];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] exp_if, exp_dm;
  int          cyc = 0, lat = 1, checks = 0, failures = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and output monitor, both acting mid-cycle on the falling edge.
  initial begin
    bit          pend;
    int          iss_cyc;
    logic        p_wr;
    logic [15:0] p_addr;
    iss_t        r;
    dn_t         dn;
    pend = 0; iss_cyc = 0; p_wr = 0; p_addr = '0;
    mem_done = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_done  = 0;
      mem_rdata = 16'($urandom);
      if (mem_en === 1'b1) begin
        r.cyc = cyc; r.wr = mem_wr; r.addr = mem_addr; r.wdata = mem_wdata;
        issues.push_back(r);
        pend = 1; iss_cyc = cyc; p_wr = mem_wr; p_addr = mem_addr;
        if (mem_wr) mem_arr[mem_addr] = mem_wdata;
      end else if (pend && lat != 0 && cyc == iss_cyc + lat) begin
        mem_done  = 1;
        mem_rdata = p_wr ? 16'hDEAD : (mem_arr.exists(p_addr) ? mem_arr[p_addr] : init_val(p_addr));
        pend = 0;
      end
      if (if_done === 1'b1) begin dn.cyc = cyc; dn.data = if_rdata; if_dones.push_back(dn); end
      if (dm_done === 1'b1) begin dn.cyc = cyc; dn.data = dm_rdata; dm_dones.push_back(dn); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    issues.delete(); if_dones.delete(); dm_dones.delete();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {26'd0, if_done, dm_done, halted, err, mem_en, mem_wr}, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_if_rdata"}, if_rdata, 0);
    chk({nm, "_dm_rdata"}, dm_rdata, 0);
  endtask

  task automatic do_reset(input string nm);
    rst = 0; if_req = 0; dm_req = 0; halt_req = 0; mem_stall = 0;
    tick(1);
    check_zero(nm);
    rst = 1; exp_if = '0; exp_dm = '0;
  endtask

  task automatic expect_issue(input string nm, input int idx, input int c, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd, input bit cmp_wd);
    if (idx < issues.size()) begin
      chk($sformatf("%s_iss%0d_cyc", nm, idx), issues[idx].cyc, c);
      chk($sformatf("%s_iss%0d_wr", nm, idx), {31'd0, issues[idx].wr}, {31'd0, wr});
      chk($sformatf("%s_iss%0d_addr", nm, idx), issues[idx].addr, a);
      if (cmp_wd) chk($sformatf("%s_iss%0d_wdata", nm, idx), issues[idx].wdata, wd);
    end
  endtask

  // One transaction from a single requester, optionally preceded by a memory stall.
  task automatic do_txn(input string nm, input bit is_data, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input int l, input int st);
    int t, d;
    bit got;
    logic [15:0] rd;
    clear_q(); lat = l;
    rd = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    t = cyc;
    mem_stall = (st > 0);
    if (is_data) begin dm_req = 1; dm_wr = wr; dm_addr = a; dm_wdata = wd; end
    else begin if_req = 1; if_addr = a; end
    got = 0; d = 0;
    for (int k = 0; k < l + st + 12 && !got; k++) begin
      tick(1);
      if (cyc == t + st) mem_stall = 0;
      if ((is_data ? dm_done : if_done) === 1'b1) begin got = 1; d = cyc; end
    end
    if_req = 0; dm_req = 0; mem_stall = 0;
    chk({nm, "_done_seen"}, {31'd0, got}, 1);
    chk({nm, "_done_cyc"}, d, t + 2 + st + l);
    chk({nm, "_n_issues"}, issues.size(), 1);
    expect_issue(nm, 0, t + 1 + st, is_data & wr, a, wd, is_data & wr);
    if (is_data && wr) ref_mem[a] = wd;
    else if (is_data)  exp_dm = rd;
    else               exp_if = rd;
    tick(1);
    chk({nm, "_other_done"}, is_data ? if_dones.size() : dm_dones.size(), 0);
    chk({nm, "_if_rdata"}, if_rdata, exp_if);
    chk({nm, "_dm_rdata"}, dm_rdata, exp_dm);
    chk({nm, "_err"}, {31'd0, err}, 0);
  endtask

  initial begin
    int t, d, e, dmc, base;
    bit got;
    logic [15:0] fa, da;
    rst = 0; if_req = 0; dm_req = 0; dm_wr = 0; halt_req = 0; mem_stall = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; exp_if = '0; exp_dm = '0;
    tick(1);
    do_reset("reset");

    mem_arr[16'h0010] = 16'hA5A5; ref_mem[16'h0010] = 16'hA5A5;
    do_txn("fetch1", 0, 0, 16'h0010, 16'h0000, 1, 0);
    do_txn("lat_max", 1, 0, 16'h0010, 16'h0000, TO - 1, 0);

    for (int i = 0; i < 24; i++) begin
      do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'h0200 + 16'($urandom_range(0, 15)), 16'($urandom),
             $urandom_range(1, TO - 1), $urandom_range(0, 3));
    end

    do_txn("stall5", 0, 0, 16'($urandom), 16'h0000, 1, 5);

    // Sustained contention: store wins first after reset, then grants alternate.
    do_reset("reset_c");
    clear_q(); lat = 1;
    fa = 16'h0300 + 16'($urandom_range(0, 255));
    if_req = 1; if_addr = fa;
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
    t = cyc; dmc = 0;
    for (int k = 0; k < 40 && dmc < 2; k++) begin
      tick(1);
      if (issues.size() >= 3) if_req = 0;
      if (dm_done === 1'b1) dmc++;
    end
    dm_req = 0; if_req = 0;
    tick(4);
    chk("cont_n_issues", issues.size(), 3);
    expect_issue("cont", 0, t + 1, 1, 16'h0100, 16'h1234, 1);
    expect_issue("cont", 1, t + 5, 0, fa, 16'h0000, 0);
    expect_issue("cont", 2, t + 9, 1, 16'h0100, 16'h1234, 1);
    ref_mem[16'h0100] = 16'h1234;
    exp_if = ref_mem.exists(fa) ? ref_mem[fa] : init_val(fa);
    chk("cont_if_dones", if_dones.size(), 1);
    chk("cont_if_rdata", if_rdata, exp_if);
    chk("cont_dm_rdata", dm_rdata, 0);

    // Reset while BUSY; the late mem_done must be ignored.
    clear_q(); lat = 5;
    if_req = 1; if_addr = 16'h0450;
    tick(3);
    rst = 0; if_req = 0;
    tick(1);
    check_zero("rst_mid");
    rst = 1; exp_if = '0; exp_dm = '0;
    tick(6);
    chk("rst_mid_no_done", if_dones.size() + dm_dones.size(), 0);
    chk("rst_mid_issues", issues.size(), 1);
    do_txn("after_rst", 0, 0, 16'h0451, 16'h0000, 2, 0);

    // Halt with a load pending and fetch requesting.
    clear_q(); lat = 2;
    da = 16'h0200 + 16'($urandom_range(0, 15));
    halt_req = 1; if_req = 1; if_addr = 16'h0777;
    dm_req = 1; dm_wr = 0; dm_addr = da;
    t = cyc; got = 0; d = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(1);
      if (dm_done === 1'b1) begin got = 1; d = cyc; end
    end
    dm_req = 0;
    exp_dm = ref_mem.exists(da) ? ref_mem[da] : init_val(da);
    chk("halt_load_done", {31'd0, got}, 1);
    chk("halt_load_cyc", d, t + 4);
    chk("halt_dm_rdata", dm_rdata, exp_dm);
    tick(1);
    chk("halt_not_yet", {31'd0, halted}, 0);
    tick(1);
    chk("halt_asserted", {31'd0, halted}, 1);
    dm_req = 1; dm_wr = 1; dm_wdata = 16'hBEEF;
    tick(10);
    chk("halt_issues", issues.size(), 1);
    chk("halt_dones", if_dones.size() + dm_dones.size(), 1);
    chk("halt_sticky", {31'd0, halted}, 1);
    do_reset("reset_h");

    // Memory that never completes.
    clear_q(); lat = 0;
    if_req = 1; if_addr = 16'h0888;
    t = cyc; got = 0; e = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick(1);
      if (err === 1'b1) begin got = 1; e = cyc; end
    end
    chk("to_err_seen", {31'd0, got}, 1);
    base = issues.size() > 0 ? issues[0].cyc : -100;
    chk("to_err_cyc", e - base, TO);
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0001;
    tick(10);
    chk("to_err_sticky", {31'd0, err}, 1);
    chk("to_issues", issues.size(), 1);
    chk("to_no_done", if_dones.size() + dm_dones.size(), 0);
    lat = 1;
    do_reset("reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle sequencer and arbiter that shares the single-ported unified memory between instruction fetch and the data-memory stage of the 16-bit processor. Memory access is the one resource both stages contend for. The arbiter grants one requester at a time, holds the transaction until the memory reports completion, and returns read data through per-requester done pulses. It also enforces the halt sequence and flags a memory that never completes.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 64, cycles after issue without mem_done before error (≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held high, if_addr stable, until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  registered fetch data, held until next fetch completes
- dm_req  in  1  data request; held high with dm_wr/dm_addr/dm_wdata stable until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_done  out  1  one-cycle pulse: data access complete, dm_rdata valid for loads
- dm_rdata  out  DATA_W  registered load data, held until next load completes
- halt_req  in  1  level; processor has decoded HALT
- halted  out  1  sticky; memory quiesced after halt
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier, valid with mem_en
- mem_addr  out  ADDR_W  address, valid with mem_en
- mem_wdata  out  DATA_W  write data, valid with mem_en
- mem_stall  in  1  memory busy; no issue allowed while high
- mem_done  in  1  one-cycle completion pulse; mem_rdata valid the same cycle
- mem_rdata  in  DATA_W  read data
- err  out  1  sticky timeout error

## Operation
- States: IDLE, ISSUE, BUSY, RESP, HALTED, ERR.
- Reset (rst=0 at an edge): state IDLE, last_grant=fetch, timeout counter 0. Every output, including if_rdata and dm_rdata, goes to 0. An in-flight access is abandoned, and a stale mem_done in the next transaction window is ignored because no issue is outstanding.
- IDLE arbitration. Evaluated only when mem_stall=0; if mem_stall=1, stay in IDLE.
  - Only dm_req high: grant data.
  - Only if_req high and halt_req=0: grant fetch.
  - Both high, halt_req=0: grant data unless last_grant=data, in which case grant fetch (alternate on contention).
  - halt_req=1: fetch is never granted.
  - halt_req=1 and dm_req=0: go to HALTED.
- On grant: latch the winner's wr/addr/wdata into the mem_* output registers and set last_grant. Go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle; fetch forces mem_wr=0. Clear the counter. Go to BUSY.
- BUSY: mem_en=0. The counter increments each cycle.
  - On mem_done: capture mem_rdata into if_rdata (fetch) or dm_rdata (load only; stores leave dm_rdata unchanged). Go to RESP.
  - If the counter reaches TIMEOUT-1 without mem_done: go to ERR.
- RESP: pulse if_done or dm_done for one cycle. Return to IDLE. Requests are not sampled in RESP, so a requester that drops req one cycle after done is never re-issued.
- HALTED: halted=1; all requests are ignored. Exit only by reset.
- ERR: err=1; no further issues and no done pulses. Exit only by reset. ERR takes precedence over halt.
- Simultaneous mem_done and timeout expiry in the same cycle: mem_done wins, go to RESP.

## Timing
- Request seen in IDLE at cycle t, memory latency L (mem_done at t+1+L) gives mem_en at t+1 and done at t+2+L.
- Minimum spacing between issues is 4 cycles when L=1 (IDLE, ISSUE, BUSY, RESP).
- mem_en, mem_wr, mem_addr and mem_wdata are registered. mem_addr and mem_wdata hold their values until the next grant.
- done pulses and the rdata registers update in the same edge-to-edge cycle; rdata is stable when done is high.
- halted asserts the cycle after IDLE observes halt_req=1 with dm_req=0.

## Test plan
- **Single fetch.** if_req=1, if_addr=0x0010, memory L=1 returns 0xA5A5. Expect mem_en at t+1 with mem_wr=0 and mem_addr=0x0010, if_done at t+3, if_rdata=0xA5A5.
- **Contention.** if_req and dm_req both held; dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234. Expect store issued first; mem_wr=1 only on the data issue. Grants alternate data, fetch, data on sustained contention. dm_rdata unchanged after the store.
- **Stall.** mem_stall=1 for 5 cycles while if_req=1. Expect no mem_en during the stall; mem_en the cycle after the cycle in which IDLE sees mem_stall=0.
- **Halt.** Raise halt_req with a load pending and if_req=1. Expect the load to complete with dm_done, no fetch issued, halted=1 one cycle after the return to IDLE, and requests ignored thereafter.
- **Timeout.** TIMEOUT=8, memory never returns mem_done. Expect err=1 eight cycles after mem_en, no done pulse, and err held until reset.
- **Reset mid-transaction.** rst=0 during BUSY. Expect all outputs 0 the next cycle and state IDLE. A late mem_done produces no done pulse, and a new fetch then completes normally.
